// File: rtl/sipm_readout_sequencer.sv
// Frame controller for the SiPM measurement channels: arms the enabled units, pulses the
// shared discharge, collects results (or times out) and streams them out in channel order.
module sipm_readout_sequencer #(
  parameter int N_CH           = 4,
  parameter int RAW_DATA_WIDTH = 10,
  parameter int DISCH_CYCLES   = 16,
  parameter int TIMEOUT        = 1023,
  parameter int CH_W           = $clog2(N_CH)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [N_CH-1:0]                i_ch_en,
  output logic                           o_busy,
  output logic [N_CH-1:0]                o_meas_rst,
  output logic                           o_discharge,
  input  logic [N_CH*RAW_DATA_WIDTH-1:0] i_meas_data,
  input  logic [N_CH-1:0]                i_meas_val,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [CH_W-1:0]                o_out_ch,
  output logic [RAW_DATA_WIDTH-1:0]      o_out_data,
  output logic                           o_out_timeout,
  output logic                           o_frame_done
);

  // state   | meaning
  // S_IDLE  | all units held in reset, waiting for start
  // S_ARM   | enabled units released, discharge low (2 cycles)
  // S_DISCH | discharge high for DISCH_CYCLES
  // S_WAIT  | waiting for all enabled results or timeout
  // S_DRAIN | streaming captured results, ascending channel
  // S_DONE  | frame_done pulse, units back in reset
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_DISCH,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int TMR_W = $clog2(DISCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DISCH_LOAD = TMR_W'(DISCH_CYCLES - 1);
  localparam logic [TMR_W-1:0] ARM_LOAD   = TMR_W'(1);

  state_t                           r_state;
  logic [N_CH-1:0]                  r_en_q;
  logic [TMR_W-1:0]                 r_tmr;
  logic [CNT_W-1:0]                 r_wait_cnt;
  logic [N_CH*RAW_DATA_WIDTH-1:0]   r_cap_data;
  logic [N_CH-1:0]                  r_cap_val;

  logic                             w_all_val;
  logic                             w_wait_exit;
  logic [N_CH-1:0]                  w_val_now;
  logic                             w_first_found;
  logic [CH_W-1:0]                  w_first_ch;
  logic                             w_next_found;
  logic [CH_W-1:0]                  w_next_ch;

  function automatic logic [RAW_DATA_WIDTH-1:0] beat_data(
    input logic [N_CH*RAW_DATA_WIDTH-1:0] data,
    input logic [N_CH-1:0]                val,
    input logic [CH_W-1:0]                ch
  );
    beat_data = val[ch] ? data[ch*RAW_DATA_WIDTH +: RAW_DATA_WIDTH] : '0;
  endfunction

  assign w_val_now   = i_meas_val & r_en_q;
  assign w_all_val   = (w_val_now == r_en_q);
  // completion wins over a simultaneous timeout, so captured flags are the real ones
  assign w_wait_exit = w_all_val || (r_wait_cnt == WAIT_LAST);

  always_comb begin
    w_first_found = 1'b0;
    w_first_ch    = '0;
    w_next_found  = 1'b0;
    w_next_ch     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_en_q[i]) begin
        w_first_found = 1'b1;
        w_first_ch    = CH_W'(i);
      end
      if (r_en_q[i] && (i > int'(o_out_ch))) begin
        w_next_found = 1'b1;
        w_next_ch    = CH_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_en_q        <= '0;
      r_tmr         <= '0;
      r_wait_cnt    <= '0;
      r_cap_data    <= '0;
      r_cap_val     <= '0;
      o_busy        <= 1'b0;
      o_meas_rst    <= '1;
      o_discharge   <= 1'b0;
      o_out_valid   <= 1'b0;
      o_out_ch      <= '0;
      o_out_data    <= '0;
      o_out_timeout <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_meas_rst   <= '1;
          o_discharge  <= 1'b0;
          o_frame_done <= 1'b0;
          if (i_start) begin
            r_en_q     <= i_ch_en;
            r_tmr      <= ARM_LOAD;
            o_busy     <= 1'b1;
            o_meas_rst <= ~i_ch_en;
            r_state    <= S_ARM;
          end
        end

        S_ARM: begin
          if (r_tmr == '0) begin
            r_tmr       <= DISCH_LOAD;
            o_discharge <= 1'b1;
            r_state     <= S_DISCH;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end

        S_DISCH: begin
          r_wait_cnt <= '0;
          if (r_tmr == '0) begin
            o_discharge <= 1'b0;
            r_state     <= S_WAIT;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end

        S_WAIT: begin
          if (w_wait_exit) begin
            r_cap_data <= i_meas_data;
            r_cap_val  <= w_val_now;
            if (w_first_found) begin
              // first beat comes from the live inputs being captured this cycle
              o_out_valid   <= 1'b1;
              o_out_ch      <= w_first_ch;
              o_out_data    <= beat_data(i_meas_data, w_val_now, w_first_ch);
              o_out_timeout <= ~w_val_now[w_first_ch];
              r_state       <= S_DRAIN;
            end else begin
              o_frame_done <= 1'b1;
              o_meas_rst   <= '1;
              r_state      <= S_DONE;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end

        S_DRAIN: begin
          if (o_out_valid && i_out_ready) begin
            if (w_next_found) begin
              o_out_ch      <= w_next_ch;
              o_out_data    <= beat_data(r_cap_data, r_cap_val, w_next_ch);
              o_out_timeout <= ~r_cap_val[w_next_ch];
            end else begin
              o_out_valid   <= 1'b0;
              o_out_ch      <= '0;
              o_out_data    <= '0;
              o_out_timeout <= 1'b0;
              o_frame_done  <= 1'b1;
              o_meas_rst    <= '1;
              r_state       <= S_DONE;
            end
          end
        end

        S_DONE: begin
          o_frame_done <= 1'b0;
          o_busy       <= 1'b0;
          o_meas_rst   <= '1;
          r_state      <= S_IDLE;
        end

        default: begin
          o_busy       <= 1'b0;
          o_meas_rst   <= '1;
          o_discharge  <= 1'b0;
          o_out_valid  <= 1'b0;
          o_frame_done <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipm_readout_sequencer.sv
// Randomized bench for sipm_readout_sequencer: a per-frame timeline model predicts every
// output cycle by cycle from the channel plan, enable mask and the ready pattern driven.
module tb_sipm_readout_sequencer;

  localparam int N_CH = 4;
  localparam int RDW  = 10;
  localparam int D    = 16;
  localparam int TMO  = 1023;
  localparam int CH_W = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [N_CH-1:0]      ch_en = '0;
  logic                 busy;
  logic [N_CH-1:0]      meas_rst;
  logic                 discharge;
  logic [N_CH*RDW-1:0]  meas_data = '0;
  logic [N_CH-1:0]      meas_val = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [CH_W-1:0]      out_ch;
  logic [RDW-1:0]       out_data;
  logic                 out_timeout;
  logic                 frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  int plan_delay[N_CH];
  int plan_data[N_CH];

  sipm_readout_sequencer #(
    .N_CH(N_CH), .RAW_DATA_WIDTH(RDW), .DISCH_CYCLES(D), .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_ch_en(ch_en),
    .o_busy(busy), .o_meas_rst(meas_rst), .o_discharge(discharge),
    .i_meas_data(meas_data), .i_meas_val(meas_val),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_ch(out_ch),
    .o_out_data(out_data), .o_out_timeout(out_timeout), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic plan_random(input logic [N_CH-1:0] tmo_mask);
    for (int i = 0; i < N_CH; i++) begin
      plan_delay[i] = tmo_mask[i] ? TMO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 20));
      plan_data[i]  = int'($urandom_range(1, 1023));
    end
  endtask

  // Cycle k is the cycle k edges after the edge that samples start.
  task automatic run_frame(input logic [N_CH-1:0] en, input int bp_pct, input bit noise,
                           input int abort_k);
    int L, m, nb, b, k0, done_k, w;
    int beat_ch[N_CH];
    int beat_dat[N_CH];
    int beat_to[N_CH];
    bit finished, aborted, exp_valid;
    logic r;
    m = -1;
    for (int i = 0; i < N_CH; i++) if (en[i] && plan_delay[i] > m) m = plan_delay[i];
    if (en == '0)        L = 1;
    else if (m <= TMO-1) L = m + 1;
    else                 L = TMO;
    nb = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (en[i]) begin
        beat_ch[nb]  = i;
        beat_to[nb]  = (plan_delay[i] > L - 1) ? 1 : 0;
        beat_dat[nb] = beat_to[nb] ? 0 : plan_data[i];
        nb++;
      end
    end
    k0 = 3 + D + L;
    done_k = (nb == 0) ? k0 : 32'h3fff_ffff;
    b = 0;
    finished = 0;
    aborted = 0;

    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1;
    ch_en = en;
    for (int k = 1; k <= 20000; k++) begin
      @(negedge clk);
      // expected outputs for cycle k
      if (k == done_k + 1) begin
        check("idle_busy_end", {31'd0, busy}, 32'd0);
        check("idle_fd", {31'd0, frame_done}, 32'd0);
        check("idle_mrst", {28'd0, meas_rst}, {28'd0, 4'hF});
        start = 1'b0;
        meas_val = '0;
        finished = 1;
        break;
      end
      exp_valid = (k >= k0) && (b < nb) && (k < done_k);
      check("busy", {31'd0, busy}, 32'd1);
      check("discharge", {31'd0, discharge}, {31'd0, (k >= 3 && k <= 2 + D)});
      check("meas_rst", {28'd0, meas_rst}, (k == done_k) ? 32'hF : {28'd0, ~en});
      check("frame_done", {31'd0, frame_done}, {31'd0, (k == done_k)});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        check("out_ch", {30'd0, out_ch}, beat_ch[b]);
        check("out_data", {22'd0, out_data}, beat_dat[b]);
        check("out_timeout", {31'd0, out_timeout}, beat_to[b]);
      end
      // inputs for cycle k
      start = noise ? ($urandom_range(0, 4) == 0) : 1'b0;
      ch_en = N_CH'($urandom);
      w = k - (3 + D);
      for (int i = 0; i < N_CH; i++) begin
        meas_val[i] = en[i] ? (w >= plan_delay[i]) : 1'($urandom);
        meas_data[i*RDW +: RDW] = (w <= L - 1) ? RDW'(plan_data[i]) : RDW'($urandom);
      end
      r = ($urandom_range(0, 99) < bp_pct);
      out_ready = r;
      if (exp_valid && r) begin
        b++;
        if (b == nb) done_k = k + 1;
      end
      if (k == abort_k) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_discharge", {31'd0, discharge}, 32'd0);
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_mrst", {28'd0, meas_rst}, 32'hF);
        check("abort_fd", {31'd0, frame_done}, 32'd0);
        start = 1'b0;
        meas_val = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
    end
    if (!finished && !aborted) check("frame_budget", 32'd0, 32'd1);
  endtask

  initial begin
    logic [N_CH-1:0] en, tm;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mrst", {28'd0, meas_rst}, 32'hF);
    check("rst_discharge", {31'd0, discharge}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ch", {30'd0, out_ch}, 32'd0);
    check("rst_data", {22'd0, out_data}, 32'd0);
    check("rst_timeout", {31'd0, out_timeout}, 32'd0);
    check("rst_fd", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;

    plan_random('0);
    for (int i = 0; i < N_CH; i++) plan_data[i] = 5 + i;
    run_frame(4'hF, 100, 0, 0);

    plan_random(4'b0100);
    run_frame(4'hF, 100, 0, 0);

    plan_random('0);
    run_frame(4'b1010, 100, 0, 0);
    run_frame(4'b0000, 100, 0, 0);

    for (int n = 0; n < 3; n++) begin
      plan_random('0);
      run_frame(4'hF, 50, 0, 0);
    end

    plan_random('0);
    run_frame(4'hF, 100, 1, 0);
    plan_random('0);
    run_frame(4'b0110, 40, 1, 0);

    plan_random('0);
    plan_delay[3] = TMO - 1;
    run_frame(4'hF, 100, 0, 0);
    plan_random('0);
    plan_delay[3] = TMO;
    run_frame(4'hF, 100, 0, 0);

    plan_random(4'b0001);
    run_frame(4'hF, 100, 0, 5);
    plan_random('0);
    run_frame(4'hF, 100, 0, 0);
    plan_random(4'b0001);
    run_frame(4'hF, 100, 0, 3 + D + 20);
    plan_random('0);
    run_frame(4'hF, 100, 0, 0);
    for (int i = 0; i < N_CH; i++) plan_delay[i] = 4;
    run_frame(4'hF, 0, 0, 3 + D + 5 + 2);
    plan_random('0);
    run_frame(4'b1011, 70, 0, 0);

    for (int n = 0; n < 20; n++) begin
      en = N_CH'($urandom);
      tm = ($urandom_range(0, 4) == 0) ? (N_CH'($urandom) & en) : '0;
      plan_random(tm);
      run_frame(en, ($urandom_range(0, 1) == 1) ? 100 : int'($urandom_range(30, 90)),
                1'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
